// File: rtl/switch_debounce_pkg.sv
// Shared switch-subsystem constants: default timing and per-bit debounce state encoding.
package switch_debounce_pkg;

    localparam int unsigned DefDebounceCycles = 1000000;
    localparam int unsigned DefSyncStages     = 2;

    localparam logic StateIdleEnc    = 1'b0;
    localparam logic StatePendingEnc = 1'b1;

    typedef enum logic {
        StIdle    = StateIdleEnc,
        StPending = StatePendingEnc
    } db_state_e;

endpackage

// File: rtl/switch_debounce_if.sv
// Raw pin / debounced switch bundle. Optional edge outputs under SWITCH_DEBOUNCE_EDGE_EN.
interface switch_debounce_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] pin_raw;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] sw_changed;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;

    modport master (output pin_raw, input sw_out, sw_changed, sw_rise, sw_fall);
    modport slave  (input pin_raw, output sw_out, sw_changed, sw_rise, sw_fall);
`else
    modport master (output pin_raw, input sw_out, sw_changed);
    modport slave  (input pin_raw, output sw_out, sw_changed);
`endif
endinterface

// File: rtl/switch_debounce_bit.sv
// One switch bit: synchroniser chain, debounce counter and IDLE/PENDING state machine.
// SWITCH_DEBOUNCE_EDGE_EN adds registered rise/fall pulses alongside changed.
module switch_debounce_bit
    import switch_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DefSyncStages,
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic rstn,
    input  logic pin,
    output logic level,
    output logic changed
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    ,
    output logic rise,
    output logic fall
`endif
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_e              state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   level_q, level_d;
    logic                   changed_q, changed_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q    <= '0;
            state_q   <= StIdle;
            count_q   <= '0;
            level_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pin};
            state_q   <= state_d;
            count_q   <= count_d;
            level_q   <= level_d;
            changed_q <= changed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        level_d   = level_q;
        changed_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s != level_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        level_d   = s;
                        changed_d = 1'b1;
                    end else begin
                        count_d = CNT_W'(1);
                        state_d = StPending;
                    end
                end
            end
            StPending: begin
                if (s == level_q) begin
                    // Glitch back to the accepted level: discard the run.
                    count_d = '0;
                    state_d = StIdle;
                end else if (count_q == CntMax) begin
                    level_d   = s;
                    count_d   = '0;
                    changed_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
            end
        endcase
    end

    assign level   = level_q;
    assign changed = changed_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic rise_q, fall_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= changed_d & level_d;
            fall_q <= changed_d & ~level_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`endif

endmodule

// File: rtl/switch_debounce.sv
// Per-bit switch synchroniser and debouncer array feeding the switch status peripheral.
// Optional SWITCH_DEBOUNCE_EDGE_EN adds sw_rise/sw_fall pulses on the interface.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = DefSyncStages,
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned CNT_W           = 20
) (
    input logic              clk,
    input logic              rstn,
    switch_debounce_if.slave bus
);

    logic [WIDTH-1:0] level_w;
    logic [WIDTH-1:0] changed_w;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk     (clk),
            .rstn    (rstn),
            .pin     (bus.pin_raw[i]),
            .level   (level_w[i]),
            .changed (changed_w[i])
`ifdef SWITCH_DEBOUNCE_EDGE_EN
            ,
            .rise    (rise_w[i]),
            .fall    (fall_w[i])
`endif
        );
    end

    assign bus.sw_out     = level_w;
    assign bus.sw_changed = changed_w;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    assign bus.sw_rise    = rise_w;
    assign bus.sw_fall    = fall_w;
`endif

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Input conditioning stage directly upstream of the switch status peripheral.
- Takes raw, asynchronous, bouncing switch pins, synchronises them to clk, and debounces each bit independently.
- Produces a clean, stable switch vector that drives the peripheral's switch_pin input, plus a per-bit one-cycle "changed" pulse.

Parameters:
- WIDTH, 4, number of switch bits.
- SYNC_STAGES, 2, flip-flop synchroniser depth per bit; legal range 2..4.
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a new level must persist before it is accepted (20 ms at 50 MHz); must be >= 1.
- CNT_W, 20, debounce counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous, active-low reset.
- pin_raw  input  WIDTH  raw switch pins, asynchronous to clk.
- sw_out  output  WIDTH  debounced switch levels, registered.
- sw_changed  output  WIDTH  one-cycle pulse per bit when the corresponding sw_out bit updates.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values: all synchroniser flops, counters, sw_out and sw_changed are 0. Per-bit state is IDLE.
- Synchroniser: each bit passes through a SYNC_STAGES flop chain. s[i] denotes the last stage.
- Per-bit state machine, two states:
  - IDLE (count = 0, s[i] == sw_out[i]). When s[i] != sw_out[i]: if DEBOUNCE_CYCLES == 1, accept immediately; otherwise count <= 1 and go to PENDING.
  - PENDING, while s[i] != sw_out[i]:
    - If count == DEBOUNCE_CYCLES-1: sw_out[i] <= s[i], count <= 0, sw_changed[i] <= 1, go to IDLE.
    - Otherwise count <= count+1.
  - PENDING, when s[i] == sw_out[i] (a glitch): count <= 0, go to IDLE, no pulse, sw_out unchanged.
- Acceptance rule: sw_out[i] takes a new value only after s[i] has differed from sw_out[i] on exactly DEBOUNCE_CYCLES consecutive rising edges. Any single-cycle return restarts the count from zero.
- Latency: a clean pin step reaches sw_out after SYNC_STAGES + DEBOUNCE_CYCLES rising edges. sw_changed asserts on the same edge that sw_out updates.
- sw_changed is high for exactly one cycle per accepted transition and is 0 on every other cycle.
- Counter: never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Bit independence: bits are fully independent. Simultaneous transitions on several bits are each counted and accepted separately, so several sw_changed bits may pulse in the same cycle.
- Reset mid-operation: everything clears asynchronously and in-progress counts are discarded. If the pins are held high through reset, sw_out rises after the full latency following rstn deassertion, with a sw_changed pulse.
- Pin toggling faster than DEBOUNCE_CYCLES: sw_out holds its last accepted value indefinitely.

Optional Feature:
- Macro SWITCH_DEBOUNCE_EDGE_EN.
- Defined: adds two outputs.
  - sw_rise (WIDTH): one-cycle pulse coincident with sw_changed when the bit goes 0->1.
  - sw_fall (WIDTH): one-cycle pulse coincident with sw_changed when the bit goes 1->0.
  - Both reset to 0. Invariant: sw_rise | sw_fall == sw_changed and sw_rise & sw_fall == 0.
- Undefined: the ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Shared include file for switch-subsystem constants: default DEBOUNCE_CYCLES, default SYNC_STAGES, and the IDLE/PENDING state encodings (localparam, 1 bit).
- One sub-module, switch_debounce_bit: a single-bit synchroniser, counter and state machine, with outputs level, changed and (with the macro) rise/fall.
- The top level instantiates WIDTH copies of switch_debounce_bit in a generate loop and concatenates their outputs.

Test Plan:
All scenarios use WIDTH=4, SYNC_STAGES=2 and DEBOUNCE_CYCLES=4.
- Reset: hold rstn=0 with pin_raw=4'hF -> sw_out=0 and sw_changed=0. Release rstn -> sw_out=4'hF after exactly 6 edges, with sw_changed=4'hF for exactly 1 cycle.
- Clean step: pin_raw 0->4'b0010 -> sw_out=4'b0010 on the 6th edge and sw_changed=4'b0010 for one cycle. No other bit changes.
- Bounce rejection: bit0 toggles high for 3 cycles, low for 1, high for 3, then low -> sw_out[0] stays 0 and sw_changed stays 0 throughout.
- Simultaneous: bits 3 and 1 rise in the same cycle -> both update on the same edge and sw_changed=4'b1010 for one cycle.
- Reset mid-count: bit2 high for 2 sync'd cycles, then pulse rstn low -> counts cleared and sw_out=0. The bit then needs a full 6 edges after release.
- Edge outputs (macro on): bit0 0->1->0 with each level stable for 10 cycles -> one sw_rise[0] pulse, then one sw_fall[0] pulse, each coincident with sw_changed[0]. Never both asserted at once.
